// File: rtl/spi_master_param.sv
// Parametrised SPI master: configurable word width, CPOL/CPHA, sck divider and slave selects.
// sck is a registered output derived from a half-period counter, so everything runs on clk.
module spi_master_param #(
  parameter int DATA_W = 8,
  parameter int NUM_SS = 4,
  parameter int DIV_W  = 8,
  parameter int SEL_W  = (NUM_SS > 1) ? $clog2(NUM_SS) : 1
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              msb_first,
  input  logic              cpol,
  input  logic              cpha,
  input  logic [DIV_W-1:0]  clk_div,
  input  logic [SEL_W-1:0]  ss_sel,
  input  logic              miso,
  output logic              sck,
  output logic              mosi,
  output logic [NUM_SS-1:0] ss_n,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              busy
);
  localparam int                EDGE_W    = $clog2(2 * DATA_W);
  localparam logic [EDGE_W-1:0] LAST_EDGE = EDGE_W'(2 * DATA_W - 1);

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_XFER, S_HOLD, S_DONE} state_t;

  state_t            state;
  logic [DIV_W-1:0]  div_cnt;
  logic [DIV_W-1:0]  div_q;
  logic [EDGE_W-1:0] edge_cnt;
  logic [DATA_W-1:0] tx_sh;
  logic [DATA_W-1:0] rx_sh;
  logic              msb_q;
  logic              cpol_q;
  logic              cpha_q;
  logic              half_done;
  logic              leading;
  logic              last_edge;

  function automatic logic first_bit(input logic [DATA_W-1:0] w, input logic msb);
    return msb ? w[DATA_W-1] : w[0];
  endfunction

  function automatic logic [DATA_W-1:0] shift_out(input logic [DATA_W-1:0] w, input logic msb);
    return msb ? {w[DATA_W-2:0], 1'b0} : {1'b0, w[DATA_W-1:1]};
  endfunction

  function automatic logic [DATA_W-1:0] shift_in(input logic [DATA_W-1:0] w, input logic b,
                                                 input logic msb);
    return msb ? {w[DATA_W-2:0], b} : {b, w[DATA_W-1:1]};
  endfunction

  // An out-of-range index matches no line, so every select stays deasserted.
  function automatic logic [NUM_SS-1:0] ss_decode(input logic [SEL_W-1:0] sel);
    logic [NUM_SS-1:0] v;
    v = '1;
    for (int i = 0; i < NUM_SS; i++) begin
      if (sel == SEL_W'(i)) v[i] = 1'b0;
    end
    return v;
  endfunction

  assign half_done = (div_cnt == div_q);
  assign leading   = ~edge_cnt[0];
  assign last_edge = (edge_cnt == LAST_EDGE);

  // NOTE: sequential state uses non-blocking assignments only, so every branch sees pre-edge values.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      // NOTE: the shift registers are reset along with control so an abandoned word never leaks out.
      state    <= S_IDLE;
      div_cnt  <= '0;
      div_q    <= '0;
      edge_cnt <= '0;
      tx_sh    <= '0;
      rx_sh    <= '0;
      msb_q    <= 1'b0;
      cpol_q   <= 1'b0;
      cpha_q   <= 1'b0;
      sck      <= 1'b0;
      mosi     <= 1'b0;
      ss_n     <= '1;
      rx_data  <= '0;
      rx_valid <= 1'b0;
      busy     <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      unique case (state)
        S_IDLE: begin
          sck      <= cpol;
          mosi     <= 1'b0;
          ss_n     <= '1;
          div_cnt  <= '0;
          edge_cnt <= '0;
          if (start) begin
            msb_q  <= msb_first;
            cpol_q <= cpol;
            cpha_q <= cpha;
            div_q  <= clk_div;
            // cpha=0 presents bit 0 during SETUP, so the register starts one shift ahead.
            tx_sh  <= cpha ? tx_data : shift_out(tx_data, msb_first);
            mosi   <= cpha ? 1'b0 : first_bit(tx_data, msb_first);
            ss_n   <= ss_decode(ss_sel);
            busy   <= 1'b1;
            state  <= S_SETUP;
          end
        end
        S_SETUP: begin
          if (half_done) begin
            div_cnt <= '0;
            state   <= S_XFER;
          end else begin
            div_cnt <= div_cnt + DIV_W'(1);
          end
        end
        S_XFER: begin
          if (half_done) begin
            div_cnt  <= '0;
            sck      <= ~sck;
            edge_cnt <= edge_cnt + EDGE_W'(1);
            if (leading ^ cpha_q) begin
              rx_sh <= shift_in(rx_sh, miso, msb_q);
            end
            if (cpha_q ? leading : (!leading && !last_edge)) begin
              mosi  <= first_bit(tx_sh, msb_q);
              tx_sh <= shift_out(tx_sh, msb_q);
            end
            if (last_edge) state <= S_HOLD;
          end else begin
            div_cnt <= div_cnt + DIV_W'(1);
          end
        end
        S_HOLD: begin
          sck <= cpol_q;
          if (half_done) begin
            div_cnt  <= '0;
            ss_n     <= '1;
            mosi     <= 1'b0;
            rx_data  <= rx_sh;
            rx_valid <= 1'b1;
            state    <= S_DONE;
          end else begin
            div_cnt <= div_cnt + DIV_W'(1);
          end
        end
        S_DONE: begin
          sck   <= cpol;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master_param.sv
// Bench for spi_master_param: an 8-bit and a 16-bit instance, a behavioural SPI slave,
// and per-scenario tasks comparing against expectations derived from the transfer rules.
module tb_spi_master_param;
  logic        clk = 1'b0;
  logic        rstn = 1'b1;
  logic        start_a = 1'b0;
  logic        start_b = 1'b0;
  logic [15:0] tx_data = '0;
  logic        msb_first = 1'b1;
  logic        cpol = 1'b0;
  logic        cpha = 1'b0;
  logic [7:0]  clk_div = '0;
  logic [2:0]  ss_sel = '0;
  logic        loop_en = 1'b1;
  logic        slave_miso = 1'b0;
  logic        use_b = 1'b0;
  logic        miso_a, miso_b;

  logic        sck_a, mosi_a, valid_a, busy_a;
  logic [3:0]  ss_n_a;
  logic [7:0]  rx_a;
  logic        sck_b, mosi_b, valid_b, busy_b;
  logic [3:0]  ss_n_b;
  logic [15:0] rx_b;

  logic        o_sck, o_mosi, o_valid, o_busy;
  logic [3:0]  o_ss_n;
  logic [15:0] o_rx;

  int checks = 0;
  int errors = 0;

  logic [15:0] s_word = '0;
  logic [15:0] s_got = '0;
  bit          s_cpha = 1'b0;
  bit          s_msb = 1'b1;
  int          s_dw = 8;
  int          s_edges = 0;
  int          s_k = 0;
  logic        s_prev = 1'b0;

  always #5 clk = ~clk;

  assign miso_a = loop_en ? mosi_a : slave_miso;
  assign miso_b = loop_en ? mosi_b : slave_miso;

  spi_master_param #(.DATA_W(8), .NUM_SS(4), .DIV_W(8)) dut_a (
    .clk(clk), .rstn(rstn), .start(start_a), .tx_data(tx_data[7:0]),
    .msb_first(msb_first), .cpol(cpol), .cpha(cpha), .clk_div(clk_div),
    .ss_sel(ss_sel[1:0]), .miso(miso_a), .sck(sck_a), .mosi(mosi_a),
    .ss_n(ss_n_a), .rx_data(rx_a), .rx_valid(valid_a), .busy(busy_a)
  );

  spi_master_param #(.DATA_W(16), .NUM_SS(4), .DIV_W(4), .SEL_W(3)) dut_b (
    .clk(clk), .rstn(rstn), .start(start_b), .tx_data(tx_data),
    .msb_first(msb_first), .cpol(cpol), .cpha(cpha), .clk_div(clk_div[3:0]),
    .ss_sel(ss_sel), .miso(miso_b), .sck(sck_b), .mosi(mosi_b),
    .ss_n(ss_n_b), .rx_data(rx_b), .rx_valid(valid_b), .busy(busy_b)
  );

  always_comb begin
    if (use_b) begin
      o_sck = sck_b; o_mosi = mosi_b; o_valid = valid_b; o_busy = busy_b;
      o_ss_n = ss_n_b; o_rx = rx_b;
    end else begin
      o_sck = sck_a; o_mosi = mosi_a; o_valid = valid_a; o_busy = busy_a;
      o_ss_n = ss_n_a; o_rx = {8'h00, rx_a};
    end
  end

  function automatic int bit_pos(input int k, input int dw, input bit msb);
    return msb ? dw - 1 - k : k;
  endfunction

  // Behavioural slave: counts sck edges of the selected master and samples/drives per mode.
  always @(negedge clk) begin
    if (o_busy !== 1'b1) begin
      s_edges = 0;
      s_prev = o_sck;
      slave_miso = s_cpha ? 1'b0 : s_word[4'(bit_pos(0, s_dw, s_msb))];
    end else if (o_sck !== s_prev) begin
      s_prev = o_sck;
      s_edges++;
      s_k = (s_edges - 1) / 2;
      if ((s_edges % 2 == 1) != s_cpha) begin
        s_got[4'(bit_pos(s_k, s_dw, s_msb))] = o_mosi;
      end else begin
        if (!s_cpha) s_k = s_edges / 2;
        if (s_k < s_dw) slave_miso = s_word[4'(bit_pos(s_k, s_dw, s_msb))];
      end
    end
  end

  task automatic run_xfer(input bit b, input logic [15:0] word, input logic [15:0] sword,
                          input bit pol, input bit pha, input bit msb, input logic [7:0] div,
                          input logic [2:0] sel, input bit loop, input string name);
    int dw, h, lat, vcount, vcycle, toggles, rises, last_t;
    int bad_ss, bad_per, bad_mosi, bad_busy;
    logic [15:0] mask, exp_rx, rx_seen;
    logic [3:0]  exp_ss;
    logic        prev;
    dw = b ? 16 : 8;
    h = int'(div) + 1;
    lat = 1 + (2 * dw + 2) * h;
    mask = b ? 16'hFFFF : 16'h00FF;
    exp_rx = (loop ? word : sword) & mask;
    vcount = 0; vcycle = -1; toggles = 0; rises = 0; last_t = -1;
    bad_ss = 0; bad_per = 0; bad_mosi = 0; bad_busy = 0; rx_seen = '0;
    @(negedge clk);
    use_b = b; tx_data = word; cpol = pol; cpha = pha; msb_first = msb;
    clk_div = div; ss_sel = sel; loop_en = loop;
    s_word = sword; s_cpha = pha; s_msb = msb; s_dw = dw;
    @(negedge clk);
    if (b) start_b = 1'b1;
    else start_a = 1'b1;
    prev = o_sck;
    @(negedge clk);
    start_a = 1'b0;
    start_b = 1'b0;
    for (int c = 1; c <= lat + 3; c++) begin
      exp_ss = (c < lat && sel < 3'd4) ? ~(4'b0001 << sel) : 4'b1111;
      if (o_ss_n !== exp_ss) bad_ss++;
      if (o_busy !== (c <= lat)) bad_busy++;
      if (c >= lat && o_mosi !== 1'b0) bad_mosi++;
      if (c <= h && o_mosi !== (pha ? 1'b0 : word[4'(msb ? dw - 1 : 0)])) bad_mosi++;
      if (o_sck !== prev) begin
        toggles++;
        if (o_sck === 1'b1) rises++;
        if (last_t >= 0 && c - last_t != h) bad_per++;
        last_t = c;
        prev = o_sck;
      end
      if (o_valid === 1'b1) begin
        vcount++;
        vcycle = c;
        rx_seen = o_rx;
      end
      @(negedge clk);
    end
    checks++; if (vcount !== 1) begin errors++; $display("FAIL %s rx_valid_pulses got %0d exp 1", name, vcount); end
    checks++; if (vcycle !== lat) begin errors++; $display("FAIL %s latency got %0d exp %0d", name, vcycle, lat); end
    checks++; if (rx_seen !== exp_rx) begin errors++; $display("FAIL %s rx_data got %0h exp %0h", name, rx_seen, exp_rx); end
    checks++; if (o_rx !== exp_rx) begin errors++; $display("FAIL %s rx_hold got %0h exp %0h", name, o_rx, exp_rx); end
    if (!loop) begin
      checks++;
      if ((s_got & mask) !== (word & mask)) begin
        errors++; $display("FAIL %s slave_rx got %0h exp %0h", name, s_got & mask, word & mask);
      end
    end
    checks++; if (toggles !== 2 * dw) begin errors++; $display("FAIL %s sck_edges got %0d exp %0d", name, toggles, 2 * dw); end
    checks++; if (rises !== dw) begin errors++; $display("FAIL %s sck_rises got %0d exp %0d", name, rises, dw); end
    checks++; if (last_t !== lat - h) begin errors++; $display("FAIL %s last_edge_cycle got %0d exp %0d", name, last_t, lat - h); end
    checks++; if (bad_per !== 0) begin errors++; $display("FAIL %s sck_half_period bad %0d exp 0", name, bad_per); end
    checks++; if (bad_ss !== 0) begin errors++; $display("FAIL %s ss_n_cycles bad %0d exp 0", name, bad_ss); end
    checks++; if (bad_busy !== 0) begin errors++; $display("FAIL %s busy_cycles bad %0d exp 0", name, bad_busy); end
    checks++; if (bad_mosi !== 0) begin errors++; $display("FAIL %s mosi_idle_setup bad %0d exp 0", name, bad_mosi); end
    checks++; if (o_sck !== pol) begin errors++; $display("FAIL %s sck_idle got %0b exp %0b", name, o_sck, pol); end
  endtask

  task automatic test_reset();
    #2 rstn = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      use_b = (i == 1);
      #1;
      checks++; if (o_sck !== 1'b0) begin errors++; $display("FAIL reset%0d sck got %0b exp 0", i, o_sck); end
      checks++; if (o_mosi !== 1'b0) begin errors++; $display("FAIL reset%0d mosi got %0b exp 0", i, o_mosi); end
      checks++; if (o_ss_n !== 4'hF) begin errors++; $display("FAIL reset%0d ss_n got %0h exp f", i, o_ss_n); end
      checks++; if (o_rx !== 16'h0) begin errors++; $display("FAIL reset%0d rx_data got %0h exp 0", i, o_rx); end
      checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL reset%0d rx_valid got %0b exp 0", i, o_valid); end
      checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL reset%0d busy got %0b exp 0", i, o_busy); end
    end
    use_b = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic test_mode0();
    run_xfer(1'b0, 16'h00A5, 16'h0000, 1'b0, 1'b0, 1'b1, 8'd0, 3'd0, 1'b1, "mode0_loop");
  endtask

  task automatic test_mode3();
    run_xfer(1'b0, 16'h0081, 16'h003C, 1'b1, 1'b1, 1'b0, 8'd3, 3'd0, 1'b0, "mode3_lsb");
  endtask

  task automatic test_ss_sel();
    run_xfer(1'b0, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
             8'd1, 3'd2, 1'b0, "ss_sel2");
    run_xfer(1'b1, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
             8'd0, 3'd5, 1'b0, "ss_sel5");
  endtask

  task automatic test_wide();
    run_xfer(1'b1, 16'hBEEF, 16'h0000, 1'b0, 1'b1, 1'($urandom), 8'($urandom_range(0, 3)),
             3'd1, 1'b1, "w16_mode1");
    run_xfer(1'b1, 16'hBEEF, 16'h0000, 1'b1, 1'b0, 1'($urandom), 8'($urandom_range(0, 3)),
             3'd3, 1'b1, "w16_mode2");
  endtask

  task automatic test_max_div();
    run_xfer(1'b0, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
             8'd255, 3'd1, 1'b0, "maxdiv_a");
    run_xfer(1'b1, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
             8'd15, 3'd0, 1'b0, "maxdiv_b");
  endtask

  task automatic test_random();
    bit b;
    for (int i = 0; i < 8; i++) begin
      b = (i % 2) == 1;
      run_xfer(b, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
               b ? 8'($urandom_range(0, 3)) : 8'($urandom_range(0, 4)),
               b ? 3'($urandom_range(0, 5)) : 3'($urandom_range(0, 3)), 1'b0, "random");
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] w0, w1, exp_w;
    int vc, idle_cnt, exp_c;
    int vcyc[3];
    logic [7:0] vrx[3];
    w0 = 8'($urandom);
    w1 = ~w0;
    vc = 0; idle_cnt = 0;
    for (int i = 0; i < 3; i++) begin vcyc[i] = -1; vrx[i] = '0; end
    @(negedge clk);
    use_b = 1'b0; tx_data = {8'h00, w0}; cpol = 1'b0; cpha = 1'b0; msb_first = 1'b1;
    clk_div = 8'd0; ss_sel = 3'd0; loop_en = 1'b1;
    @(negedge clk);
    start_a = 1'b1;
    for (int c = 1; c <= 80; c++) begin
      @(negedge clk);
      if (c == 25) tx_data = {8'h00, w1};
      if (c == 60) start_a = 1'b0;
      if (c < 60 && o_busy !== 1'b1) idle_cnt++;
      if (o_valid === 1'b1) begin
        if (vc < 3) begin vcyc[vc] = c; vrx[vc] = o_rx[7:0]; end
        vc++;
      end
    end
    checks++; if (vc !== 3) begin errors++; $display("FAIL b2b pulses got %0d exp 3", vc); end
    checks++; if (idle_cnt !== 2) begin errors++; $display("FAIL b2b idle_cycles got %0d exp 2", idle_cnt); end
    for (int i = 0; i < 3; i++) begin
      exp_c = 1 + (2 * 8 + 2) + 20 * i;
      exp_w = (i < 2) ? w0 : w1;
      checks++; if (vcyc[i] !== exp_c) begin errors++; $display("FAIL b2b cycle%0d got %0d exp %0d", i, vcyc[i], exp_c); end
      checks++; if (vrx[i] !== exp_w) begin errors++; $display("FAIL b2b rx%0d got %0h exp %0h", i, vrx[i], exp_w); end
    end
  endtask

  task automatic test_reset_mid();
    int toggles, vcount;
    bit hit;
    logic prev;
    @(negedge clk);
    use_b = 1'b0; tx_data = 16'($urandom); cpol = 1'b1; cpha = 1'b0; msb_first = 1'b1;
    clk_div = 8'($urandom_range(0, 2)); ss_sel = 3'd0; loop_en = 1'b1;
    @(negedge clk);
    start_a = 1'b1;
    prev = o_sck;
    @(negedge clk);
    start_a = 1'b0;
    toggles = 0;
    hit = 1'b0;
    for (int c = 1; c <= 200 && !hit; c++) begin
      if (o_sck !== prev) begin toggles++; prev = o_sck; end
      if (toggles == 4) hit = 1'b1;
      else @(negedge clk);
    end
    checks++; if (!hit) begin errors++; $display("FAIL rst_mid edge4_seen got %0d edges exp 4", toggles); end
    rstn = 1'b0;
    #1;
    checks++; if (sck_a !== 1'b0) begin errors++; $display("FAIL rst_mid sck got %0b exp 0", sck_a); end
    checks++; if (ss_n_a !== 4'hF) begin errors++; $display("FAIL rst_mid ss_n got %0h exp f", ss_n_a); end
    checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL rst_mid busy got %0b exp 0", busy_a); end
    checks++; if (mosi_a !== 1'b0) begin errors++; $display("FAIL rst_mid mosi got %0b exp 0", mosi_a); end
    checks++; if (rx_a !== 8'h00) begin errors++; $display("FAIL rst_mid rx_data got %0h exp 0", rx_a); end
    @(negedge clk);
    rstn = 1'b1;
    vcount = 0;
    for (int c = 0; c < 60; c++) begin
      if (valid_a === 1'b1) vcount++;
      @(negedge clk);
    end
    checks++; if (vcount !== 0) begin errors++; $display("FAIL rst_mid late_valid got %0d exp 0", vcount); end
    run_xfer(1'b0, 16'($urandom), 16'($urandom), 1'b1, 1'b0, 1'($urandom), 8'd1, 3'd3, 1'b0,
             "after_reset");
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_mode0();
    test_mode3();
    test_ss_sel();
    test_wide();
    test_max_div();
    test_random();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
